// File: rtl/serial_mod_divider_if.sv
// Word/result handshake bundle for serial_mod_divider.
// The quotient signal exists only when SERIAL_MOD_QUOTIENT_EN is defined.
interface serial_mod_divider_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DIV_W  = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] data_in;
  logic [DIV_W-1:0]  divisor;
  logic              out_valid;
  logic              out_ready;
  logic [DIV_W-1:0]  remainder;
  logic              div_err;
  logic              busy;
`ifdef SERIAL_MOD_QUOTIENT_EN
  logic [DATA_W-1:0] quotient;

  modport master (
    output in_valid, data_in, divisor, out_ready,
    input  in_ready, out_valid, remainder, div_err, busy, quotient
  );
  modport slave (
    input  in_valid, data_in, divisor, out_ready,
    output in_ready, out_valid, remainder, div_err, busy, quotient
  );
`else
  modport master (
    output in_valid, data_in, divisor, out_ready,
    input  in_ready, out_valid, remainder, div_err, busy
  );
  modport slave (
    input  in_valid, data_in, divisor, out_ready,
    output in_ready, out_valid, remainder, div_err, busy
  );
`endif
endinterface

// File: rtl/serial_mod_divider.sv
// Bit-serial restoring divider: one dividend bit per enabled cycle, MSB first.
// Define SERIAL_MOD_QUOTIENT_EN to build the quotient output and its register.
module serial_mod_divider #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DIV_W  = 8,
  parameter int unsigned CNT_W  = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  serial_mod_divider_if.slave   bus
);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [DIV_W-1:0]  rem_q, rem_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;
  logic [DIV_W-1:0]  rem_o_q, rem_o_d;
  logic              err_o_q, err_o_d;
  logic [DIV_W:0]    t;
  logic              ge;
`ifdef SERIAL_MOD_QUOTIENT_EN
  logic [DATA_W-1:0] quo_o_q, quo_o_d;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      sh_q    <= '0;
      div_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      rem_o_q <= '0;
      err_o_q <= 1'b0;
`ifdef SERIAL_MOD_QUOTIENT_EN
      quo_o_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      div_q   <= div_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      rem_o_q <= rem_o_d;
      err_o_q <= err_o_d;
`ifdef SERIAL_MOD_QUOTIENT_EN
      quo_o_q <= quo_o_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    div_d   = div_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    rem_o_d = rem_o_q;
    err_o_d = err_o_q;
`ifdef SERIAL_MOD_QUOTIENT_EN
    quo_o_d = quo_o_q;
`endif
    t  = {rem_q, sh_q[DATA_W-1]};
    ge = (t >= {1'b0, div_q});

    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          sh_d    = bus.data_in;
          div_d   = bus.divisor;
          rem_d   = '0;
          cnt_d   = '0;
          err_d   = (bus.divisor == '0);
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        // A zero divisor spends one SHIFT cycle regardless of enable, so its
        // result appears one edge after the accept.
        if (err_q) begin
          state_d = S_DONE;
          rem_o_d = '0;
          err_o_d = 1'b1;
`ifdef SERIAL_MOD_QUOTIENT_EN
          quo_o_d = '1;
`endif
        end else if (enable) begin
          rem_d = ge ? DIV_W'(t - {1'b0, div_q}) : t[DIV_W-1:0];
          // Quotient bits enter at the LSB as dividend bits leave the MSB.
`ifdef SERIAL_MOD_QUOTIENT_EN
          sh_d  = {sh_q[DATA_W-2:0], ge};
`else
          sh_d  = {sh_q[DATA_W-2:0], 1'b0};
`endif
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(DATA_W - 1)) begin
            state_d = S_DONE;
            rem_o_d = rem_d;
            err_o_d = 1'b0;
`ifdef SERIAL_MOD_QUOTIENT_EN
            quo_o_d = sh_d;
`endif
          end
        end
      end
      S_DONE: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.busy      = (state_q == S_SHIFT);
  assign bus.remainder = rem_o_q;
  assign bus.div_err   = err_o_q;
`ifdef SERIAL_MOD_QUOTIENT_EN
  assign bus.quotient  = quo_o_q;
`endif

endmodule
